// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB arbiter: requester ordering, slot index type, age defaults.
// Requester indices are laid out loads first, then mults, then ALUs, so long-latency units win ties.
package cdb_arbiter_pkg;

    localparam int NUM_FU_LOAD    = 2;
    localparam int NUM_FU_MULT    = 2;
    localparam int NUM_FU_ALU     = 4;
    localparam int CDB_N          = 2;
    localparam int CDB_NUM_REQ    = NUM_FU_LOAD + NUM_FU_MULT + NUM_FU_ALU;
    localparam int CDB_IDX_W      = $clog2(CDB_NUM_REQ);
    localparam int CDB_STARVE_LIM = 3;
    localparam int AGE_W          = 4;

    localparam int FU_LOAD_BASE = 0;
    localparam int FU_MULT_BASE = FU_LOAD_BASE + NUM_FU_LOAD;
    localparam int FU_ALU_BASE  = FU_MULT_BASE + NUM_FU_MULT;

    typedef logic [CDB_IDX_W-1:0] CDB_ARB_IDX;

    typedef enum logic [1:0] {
        FU_LOAD = 2'd0,
        FU_MULT = 2'd1,
        FU_ALU  = 2'd2
    } fu_class_e;

    function automatic fu_class_e fu_class_of(input CDB_ARB_IDX idx);
        if (int'(idx) < FU_MULT_BASE) return FU_LOAD;
        if (int'(idx) < FU_ALU_BASE)  return FU_MULT;
        return FU_ALU;
    endfunction

endpackage

// File: rtl/cdb_arbiter_psel_multi.sv
// Multi-grant ascending priority selector: picks up to max_i set bits of mask_i, lowest index first,
// returning the grant mask, the picked indices in order, and how many were picked.
module cdb_psel_multi #(
    parameter int NUM_REQ = 8,
    parameter int NUM_GNT = 2,
    parameter int IDX_W   = 3,
    parameter int CNT_W   = $clog2(NUM_GNT + 1)
) (
    input  logic [NUM_REQ-1:0]            mask_i,
    input  logic [CNT_W-1:0]              max_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_GNT-1:0]            valid_o,
    output logic [NUM_GNT-1:0][IDX_W-1:0] idx_o,
    output logic [CNT_W-1:0]              cnt_o
);

    logic [CNT_W-1:0] cnt;

    always_comb begin
        gnt_o   = '0;
        valid_o = '0;
        idx_o   = '0;
        cnt     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mask_i[i] && (cnt < max_i)) begin
                for (int k = 0; k < NUM_GNT; k++) begin
                    if (cnt == CNT_W'(k)) begin
                        valid_o[k] = 1'b1;
                        idx_o[k]   = IDX_W'(i);
                    end
                end
                gnt_o[i] = 1'b1;
                cnt      = cnt + 1'b1;
            end
        end
        cnt_o = cnt;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Age-aware multi-grant CDB arbiter; starved requesters are promoted ahead of fixed priority.
// Age counters exist only when CDB_ARB_AGE_EN is defined; otherwise the block is pure fixed priority.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = CDB_NUM_REQ,
    parameter int NUM_GNT    = CDB_N,
    parameter int STARVE_LIM = CDB_STARVE_LIM,
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic                          squash_i,
    input  logic [NUM_REQ-1:0]            req_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            avail_o,
    output logic [NUM_GNT-1:0]            slot_valid_o,
    output logic [NUM_GNT-1:0][IDX_W-1:0] slot_idx_o
);

    localparam int CNT_W = $clog2(NUM_GNT + 1);

    logic                          blocked;
    logic [NUM_REQ-1:0]            starved;
    logic [NUM_REQ-1:0]            gnt_s;
    logic [NUM_REQ-1:0]            gnt_r;
    logic [NUM_REQ-1:0]            gnt_raw;
    logic [NUM_GNT-1:0]            vld_s;
    logic [NUM_GNT-1:0]            vld_r;
    logic [NUM_GNT-1:0][IDX_W-1:0] idx_s;
    logic [NUM_GNT-1:0][IDX_W-1:0] idx_r;
    logic [CNT_W-1:0]              cnt_s;
    logic [CNT_W-1:0]              cnt_r;
    logic [CNT_W-1:0]              room_r;

    assign blocked = reset_i | squash_i;

`ifdef CDB_ARB_AGE_EN
    logic [NUM_REQ-1:0][AGE_W-1:0] age_q;
    logic [NUM_REQ-1:0][AGE_W-1:0] age_d;

    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            starved[i] = req_i[i] && (age_q[i] == AGE_W'(STARVE_LIM));
        end
    end

    // Saturating age: cleared on grant, idle or flush, never wraps past the limit.
    always_comb begin
        age_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (squash_i || !req_i[i] || gnt_raw[i]) begin
                age_d[i] = '0;
            end else if (age_q[i] >= AGE_W'(STARVE_LIM)) begin
                age_d[i] = AGE_W'(STARVE_LIM);
            end else begin
                age_d[i] = age_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    logic unused_cfg;

    assign starved    = '0;
    assign unused_cfg = clock_i ^ STARVE_LIM[0];
`endif

    cdb_psel_multi #(
        .NUM_REQ (NUM_REQ),
        .NUM_GNT (NUM_GNT),
        .IDX_W   (IDX_W),
        .CNT_W   (CNT_W)
    ) u_psel_starved (
        .mask_i  (starved),
        .max_i   (CNT_W'(NUM_GNT)),
        .gnt_o   (gnt_s),
        .valid_o (vld_s),
        .idx_o   (idx_s),
        .cnt_o   (cnt_s)
    );

    // The fixed-priority pass only gets the slots the starved pass left over.
    assign room_r = CNT_W'(NUM_GNT) - cnt_s;

    cdb_psel_multi #(
        .NUM_REQ (NUM_REQ),
        .NUM_GNT (NUM_GNT),
        .IDX_W   (IDX_W),
        .CNT_W   (CNT_W)
    ) u_psel_rest (
        .mask_i  (req_i & ~starved),
        .max_i   (room_r),
        .gnt_o   (gnt_r),
        .valid_o (vld_r),
        .idx_o   (idx_r),
        .cnt_o   (cnt_r)
    );

    assign gnt_raw = gnt_s | gnt_r;
    assign gnt_o   = blocked ? '0 : gnt_raw;
    assign avail_o = blocked ? '1 : (~req_i | gnt_raw);

    always_comb begin
        slot_valid_o = '0;
        slot_idx_o   = '0;
        if (!blocked) begin
            for (int k = 0; k < NUM_GNT; k++) begin
                slot_valid_o[k] = CNT_W'(k) < (cnt_s + cnt_r);
                if (vld_s[k]) begin
                    slot_idx_o[k] = idx_s[k];
                end else begin
                    for (int j = 0; j < NUM_GNT; j++) begin
                        if (vld_r[j] && ((CNT_W'(j) + cnt_s) == CNT_W'(k))) begin
                            slot_idx_o[k] = idx_r[j];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter with a queue-based ordering model (8 requesters, 2 slots, limit 3).
module tb_cdb_arbiter;

    localparam int NREQ = 8;
    localparam int NGNT = 2;
    localparam int LIM  = 3;
    localparam int IW   = 3;
`ifdef CDB_ARB_AGE_EN
    localparam bit AGE_EN = 1'b1;
`else
    localparam bit AGE_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     sq  = 1'b0;
    logic [NREQ-1:0]          req = '0;
    logic [NREQ-1:0]          gnt;
    logic [NREQ-1:0]          avail;
    logic [NGNT-1:0]          slot_valid;
    logic [NGNT-1:0][IW-1:0]  slot_idx;
    logic [23:0]              dut_vec;

    int m_age [NREQ];
    int n_checks = 0;
    int n_errors = 0;

    cdb_arbiter #(
        .NUM_REQ    (NREQ),
        .NUM_GNT    (NGNT),
        .STARVE_LIM (LIM),
        .IDX_W      (IW)
    ) dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .squash_i     (sq),
        .req_i        (req),
        .gnt_o        (gnt),
        .avail_o      (avail),
        .slot_valid_o (slot_valid),
        .slot_idx_o   (slot_idx)
    );

    always #5 clk = ~clk;

    assign dut_vec = {gnt, slot_valid, slot_idx, avail};

    // Expected {gnt, slot_valid, slot_idx, avail}: starved list then the rest, first NGNT taken.
    function automatic logic [23:0] model_eval(input logic [7:0] r, input logic s, input logic rs);
        int order[$];
        logic [7:0]      g;
        logic [1:0]      v;
        logic [1:0][2:0] ix;
        g  = '0;
        v  = '0;
        ix = '0;
        if (rs || s) return {8'h00, 2'b00, 6'h00, 8'hFF};
        for (int i = 0; i < NREQ; i++)
            if (r[i] && AGE_EN && m_age[i] == LIM) order.push_back(i);
        for (int i = 0; i < NREQ; i++)
            if (r[i] && !(AGE_EN && m_age[i] == LIM)) order.push_back(i);
        for (int k = 0; k < NGNT && k < order.size(); k++) begin
            g[order[k]] = 1'b1;
            v[k]        = 1'b1;
            ix[k]       = 3'(order[k]);
        end
        return {g, v, ix, ~r | g};
    endfunction

    function automatic void model_clock(input logic [7:0] r, input logic s);
        logic [23:0] e;
        e = model_eval(r, s, 1'b0);
        for (int i = 0; i < NREQ; i++) begin
            if (s || !r[i] || e[16+i]) m_age[i] = 0;
            else if (m_age[i] < LIM)   m_age[i] = m_age[i] + 1;
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        sq  = 1'b0;
        #2;
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) m_age[i] = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req = 8'hFF;
        #2;
        n_checks++;
        if (dut_vec !== {8'h00, 2'b00, 6'h00, 8'hFF}) begin
            n_errors++;
            $display("FAIL reset_async got=%h want=%h", dut_vec, {8'h00, 2'b00, 6'h00, 8'hFF});
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (dut_vec !== {8'h00, 2'b00, 6'h00, 8'hFF}) begin
            n_errors++;
            $display("FAIL reset_held got=%h want=%h", dut_vec, {8'h00, 2'b00, 6'h00, 8'hFF});
        end
        do_reset();
    endtask

    task automatic test_held_full();
        logic [7:0]  tab [7];
        logic [23:0] exp_v;
`ifdef CDB_ARB_AGE_EN
        tab = '{8'h03, 8'h03, 8'h03, 8'h0C, 8'h30, 8'hC0, 8'h03};
`else
        tab = '{8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03};
`endif
        do_reset();
        for (int c = 0; c < 7; c++) begin
            req = 8'hFF;
            sq  = 1'b0;
            #1;
            exp_v = model_eval(req, sq, rst);
            n_checks++;
            if (gnt !== tab[c]) begin
                n_errors++;
                $display("FAIL held_full_gnt c=%0d got=%h want=%h", c, gnt, tab[c]);
            end
            n_checks++;
            if (dut_vec !== exp_v) begin
                n_errors++;
                $display("FAIL held_full_model c=%0d got=%h want=%h", c, dut_vec, exp_v);
            end
`ifdef CDB_ARB_AGE_EN
            if (c == 3) begin
                n_checks++;
                if (slot_idx !== {3'd3, 3'd2}) begin
                    n_errors++;
                    $display("FAIL held_full_slots got=%h want=%h", slot_idx, {3'd3, 3'd2});
                end
            end
`endif
            model_clock(req, sq);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_idle();
        for (int c = 0; c < 3; c++) begin
            req = 8'h00;
            sq  = 1'b0;
            #1;
            n_checks++;
            if (dut_vec !== {8'h00, 2'b00, 6'h00, 8'hFF}) begin
                n_errors++;
                $display("FAIL idle c=%0d got=%h want=%h", c, dut_vec, {8'h00, 2'b00, 6'h00, 8'hFF});
            end
            model_clock(req, sq);
            @(posedge clk);
            #1;
        end
        req = 8'hFF;
        #1;
        n_checks++;
        if (gnt !== 8'h03) begin
            n_errors++;
            $display("FAIL idle_then_full got=%h want=03", gnt);
        end
        model_clock(req, sq);
        @(posedge clk);
        #1;
    endtask

    task automatic test_squash();
        logic [7:0] tab [4];
        tab = '{8'h03, 8'h03, 8'h00, 8'h03};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            req = 8'hFF;
            sq  = (c == 2);
            #1;
            n_checks++;
            if (gnt !== tab[c]) begin
                n_errors++;
                $display("FAIL squash_gnt c=%0d got=%h want=%h", c, gnt, tab[c]);
            end
            if (sq) begin
                n_checks++;
                if ({avail, slot_valid, slot_idx} !== {8'hFF, 2'b00, 6'h00}) begin
                    n_errors++;
                    $display("FAIL squash_outs got=%h want=%h", {avail, slot_valid, slot_idx}, {8'hFF, 2'b00, 6'h00});
                end
            end
            model_clock(req, sq);
            @(posedge clk);
            #1;
        end
        sq = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h80;
        #1;
        n_checks++;
        if (dut_vec !== {8'h80, 2'b01, 3'd0, 3'd7, 8'hFF}) begin
            n_errors++;
            $display("FAIL single got=%h want=%h", dut_vec, {8'h80, 2'b01, 3'd0, 3'd7, 8'hFF});
        end
        model_clock(req, sq);
        @(posedge clk);
        #1;
    endtask

    task automatic test_midrun_reset();
        logic [7:0] want3;
        want3 = AGE_EN ? 8'h0C : 8'h03;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            req = 8'hFF;
            model_clock(req, sq);
            @(posedge clk);
            #1;
        end
        #1;
        n_checks++;
        if (gnt !== want3) begin
            n_errors++;
            $display("FAIL midrun_before got=%h want=%h", gnt, want3);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (dut_vec !== {8'h00, 2'b00, 6'h00, 8'hFF}) begin
            n_errors++;
            $display("FAIL midrun_async got=%h want=%h", dut_vec, {8'h00, 2'b00, 6'h00, 8'hFF});
        end
        @(posedge clk);
        @(negedge clk);
        req = 8'h00;
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) m_age[i] = 0;
        @(posedge clk);
        #1;
        req = 8'hFF;
        #1;
        n_checks++;
        if (gnt !== 8'h03) begin
            n_errors++;
            $display("FAIL midrun_after got=%h want=03", gnt);
        end
        model_clock(req, sq);
        @(posedge clk);
        #1;
    endtask

    task automatic test_no_age();
`ifndef CDB_ARB_AGE_EN
        do_reset();
        for (int c = 0; c < 10; c++) begin
            req = 8'hFF;
            #1;
            n_checks++;
            if ({gnt, avail} !== {8'h03, 8'h03}) begin
                n_errors++;
                $display("FAIL no_age c=%0d got=%h want=%h", c, {gnt, avail}, {8'h03, 8'h03});
            end
            model_clock(req, sq);
            @(posedge clk);
            #1;
        end
`endif
    endtask

    task automatic test_random();
        logic [23:0] exp_v;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            req = (c % 3 == 0) ? 8'($urandom) : 8'($urandom | $urandom);
            sq  = ($urandom_range(0, 15) == 0);
            #1;
            exp_v = model_eval(req, sq, rst);
            n_checks++;
            if (dut_vec !== exp_v) begin
                n_errors++;
                $display("FAIL random c=%0d req=%h sq=%b got=%h want=%h", c, req, sq, dut_vec, exp_v);
            end
            model_clock(req, sq);
            @(posedge clk);
            #1;
        end
        sq = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp_v;
        logic [7:0]  pend;
        do_reset();
        pend = 8'($urandom);
        for (int c = 0; c < 200; c++) begin
            req = pend;
            #1;
            exp_v = model_eval(req, 1'b0, 1'b0);
            n_checks++;
            if (dut_vec !== exp_v) begin
                n_errors++;
                $display("FAIL back_to_back c=%0d req=%h got=%h want=%h", c, req, dut_vec, exp_v);
            end
            model_clock(req, 1'b0);
            pend = (pend & ~exp_v[23:16]) | (8'($urandom) & 8'($urandom));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) m_age[i] = 0;
        test_reset();
        test_held_full();
        test_idle();
        test_squash();
        test_single();
        test_midrun_reset();
        test_no_age();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Age-aware multi-grant arbiter that shares the `N` common-data-bus slots among all FU result requesters (ALU, mult, load). Each cycle it grants up to NUM_GNT requesters and maps each grant to a CDB slot. It also returns per-FU availability so stalled FUs hold their result. Base policy is fixed priority (lowest index wins). Optional age counters promote starved requesters ahead of the fixed order.

## Interface
- NUM_REQ, default `NUM_FU_ALU+`NUM_FU_MULT+`NUM_FU_LOAD: number of requesters; index 0 has highest base priority.
- NUM_GNT, default `N: CDB slots per cycle.
- STARVE_LIM, default 3: age at which a requester counts as starved; range 1..15.
- IDX_W, default $clog2(NUM_REQ): slot index width.
- clock  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- squash  in  1  synchronous pipeline flush.
- req  in  NUM_REQ  FU i holds a completed result.
- gnt  out  NUM_REQ  FU i drives the CDB this cycle.
- avail  out  NUM_REQ  FU i may accept a new op next cycle; equals ~req[i] | gnt[i].
- slot_valid  out  NUM_GNT  CDB slot k is carrying a result.
- slot_idx  out  NUM_GNT x IDX_W  requester index placed on slot k.

## Operation
- Outputs are combinational from req, squash, reset and the age state. The only state is age[i] (4 bits each), present only under the macro.
- Selection order:
  - Starved requesters (req[i] && age[i]==STARVE_LIM), in ascending index.
  - Then non-starved requesters, in ascending index.
  - Take the first NUM_GNT in this order.
- Slot k receives the k-th selection. slot_valid is contiguous from slot 0. Unused slots have slot_valid=0 and slot_idx=0.
- popcount(gnt) == popcount(slot_valid) <= NUM_GNT at all times.
- Age update at posedge clock:
  - squash, or req[i]==0, or gnt[i]==1: age[i] <= 0.
  - Otherwise: age[i] <= min(age[i]+1, STARVE_LIM). The counter saturates and never wraps.
- While squash==1 or reset==1:
  - gnt=0, slot_valid=0, slot_idx=0.
  - avail = all ones.
- When req is all zeros: no grants, avail all ones, ages all 0 after the edge.

## Timing
- Grant latency is 0 cycles: a req seen in cycle t can be granted in cycle t. The grant is a single-cycle pulse.
- Handshake: an FU holds req (and its result) until the cycle in which gnt is seen, and deasserts req the next cycle unless a new result is ready. req may stay high across consecutive cycles for back-to-back results.
- Reset is asynchronous: ages go to 0 immediately. First grant is possible in the first cycle after reset deasserts.
- Squash takes priority over the age update in the same edge. Reset overrides squash.
- Reset values of all outputs: gnt=0, slot_valid=0, slot_idx=0, avail=all ones.

## Configuration
- CDB_ARB_AGE_EN defined:
  - Age counters are built and starved requesters are promoted as above.
  - Guaranteed service within STARVE_LIM + ceil(NUM_REQ/NUM_GNT) cycles while req is held.
- CDB_ARB_AGE_EN undefined:
  - No state; pure fixed priority; STARVE_LIM is ignored.
  - Block is purely combinational apart from squash/reset gating.
  - High indices may starve indefinitely.

## Structure
- Shared package (sys_defs.svh) holds:
  - The `CDB_ARB_IDX` typedef, width IDX_W.
  - The `CDB_STARVE_LIM` default constant.
  - The requester index ordering: loads, then mults, then ALUs. Long-latency units get base priority.
- One sub-module, `cdb_psel_multi`: an NUM_GNT-way ascending priority selector over a NUM_REQ mask. It returns the grant mask plus the ordered indices.
  - Instantiated twice, for the starved mask and the remaining mask.
  - The second instance's grant width is reduced by the first instance's count.

## Test plan
All scenarios use NUM_REQ=8, NUM_GNT=2, STARVE_LIM=3, macro defined, and start from reset.
- **Held full request:** req=8'hFF held. Required gnt per cycle: 03, 03, 03, 0C, 30, C0, 03. Cycle 3 gives slot_idx={2,3}.
- **Idle:** req=8'h00 → gnt=0, slot_valid=2'b00, avail=8'hFF. No age change.
- **Squash:** same as the held full request, but squash=1 in cycle 2. Required: cycle 2 gnt=0 and avail=FF; cycle 3 gnt=03, because the ages were cleared.
- **Single requester:** req=8'h80 → gnt=80, slot_valid=2'b01, slot_idx[0]=7.
- **Mid-run reset:** assert reset asynchronously mid-cycle while gnt=0C. Outputs must zero without waiting for a clock edge. After release, req=FF gives gnt=03.
- **Macro undefined:** req=FF held for 10 cycles → gnt=03 every cycle and avail=8'h03.
